dsp_version_query: RTL and testbench
====================================

Name: dsp_version_query

Overview:
- Downstream stage of the port scanner: takes the base port accepted by the DSP reset scan (0x200..0x2F0) and runs the SB DSP "get version" exchange over the ISA bus.
- Sequence: poll write-buffer status, write command 0xE1, poll read-data-available, read major, poll again, read minor.
- Presents the version bytes and done/error flags to the riser control logic.
- Generates its own ISA I/O strobes from sys_clock; there is no separate bus clock.

Parameters:
STROBE_CYCLES, 8, width of the IOR#/IOW# active-low pulse in sys_clock cycles (min 2)
TIMEOUT_BITS, 16, width of the poll-attempt counter; all-ones means timeout
DSP_CMD, 8'hE1, command byte written to base+0xC

Ports:
sys_clock  in  1  system clock; all logic rising-edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a query
base_addr  in  16  detected DSP base port, latched on accepted start
data_in  in  16  ISA data bus read value; bits [7:0] used
data_out  out  16  ISA write data; {8'h00, byte}
address  out  16  ISA I/O address
data_dir  out  1  1 = drive data_out (write), 0 = tri-state/read
iow_n  out  1  ISA I/O write strobe, active-low
ior_n  out  1  ISA I/O read strobe, active-low
busy  out  1  query in progress
done  out  1  query succeeded; level-held until next accepted start
error  out  1  timeout or illegal base; level-held until next accepted start
version_major  out  8  first byte read from base+0xA
version_minor  out  8  second byte read from base+0xA

Behaviour:
- Reset, and async assertion mid-operation: address=0, data_out=0, data_dir=0, iow_n=1, ior_n=1, busy=0, done=0, error=0, version_*=0. State returns to IDLE. Any strobe in flight is aborted immediately.
- Bus access takes STROBE_CYCLES+2 cycles:
  - 1 setup cycle: address and data_dir valid, strobes high.
  - STROBE_CYCLES cycles with the strobe low.
  - Read data sampled on the last low cycle.
  - 1 recovery cycle: strobe high, address held.
- data_dir is 1 only from setup through recovery of a write access; otherwise 0.
- start is accepted only in IDLE, DONE or ERR. Accepting it latches base_addr, clears done, error and the version regs, and sets busy next cycle. start while busy is ignored.
- Illegal base: base_addr[3:0] != 0, or base_addr outside 0x200..0x2F0. Result: ERR on the next cycle, no bus activity, busy stays 0.
- States:
  - IDLE.
  - WPOLL: read base+0xC; bit7=0 -> WCMD, else repeat.
  - WCMD: write DSP_CMD to base+0xC -> RPOLL1.
  - RPOLL1: read base+0xE; bit7=1 -> RDAT1, else repeat.
  - RDAT1: read base+0xA into version_major -> RPOLL2.
  - RPOLL2: same test as RPOLL1 -> RDAT2.
  - RDAT2: read base+0xA into version_minor -> DONE.
  - DONE: done=1, busy=0.
  - ERR: error=1, busy=0.
- Timeout: one attempt counter, cleared on entry to each poll state, incremented per failed poll. Reaching all-ones sends the FSM to ERR after that access's recovery cycle. The counter saturates and never wraps.
- Latency with the DSP always ready: 6 accesses, so done rises 6*(STROBE_CYCLES+2)+1 cycles after start. That is 61 cycles at the default.
- version_* change only at the RDAT sample point; they stay stable in DONE and read 0 in ERR.
- Only one strobe is ever low at a time. ior_n and iow_n are never simultaneously 0.

Decomposition:
- Shared package holds:
  - state encoding;
  - port offsets: OFF_WSTAT=4'hC, OFF_RSTAT=4'hE, OFF_RDATA=4'hA;
  - base window constants 16'h0200/16'h02F0;
  - DSP_CMD_GET_VERSION=8'hE1.
- Sub-module isa_io_cycle performs one access. Inputs: req, wr, addr, wdata. Outputs: ior_n, iow_n, data_dir, rdata, ack (one-cycle pulse in the recovery cycle). It is parameterised by STROBE_CYCLES.
- dsp_version_query is the FSM plus the timeout counter.

Test Plan:
- Model returns C=0x00, E=0x80, A=0x04 then 0x05; start with base 0x220 → one write of 0xE1 to 0x22C; done=1 at cycle 61; major=0x04, minor=0x05; error=0.
- Model holds 0x22C bit7=1 for 3 polls then 0 → exactly 4 reads of 0x22C before the write; done at cycle 61+3*10=91.
- TIMEOUT_BITS=4, model never sets 0x22E bit7 → 15 reads of 0x22E, then error=1, done=0, version regs 0, busy=0.
- start with base 0x225, then 0x300 → error=1 next cycle; ior_n and iow_n stay 1 throughout.
- Assert reset during the RDAT1 strobe-low phase → outputs at reset values with no clock edge needed; a later start with base 0x240 completes normally.
- Pulse start again at cycle 20 of a running query → ignored; the address sequence and done timing are unchanged; ior_n and iow_n are never both 0 (checked by assertion throughout).

Source files
------------

// File: rtl/dsp_version_query_pkg.sv
// Shared definitions for the SB DSP version query: FSM and bus-phase encodings,
// DSP port offsets, the legal base-port window and the get-version command.
package dsp_version_query_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WPOLL,
    ST_WCMD,
    ST_RPOLL1,
    ST_RDAT1,
    ST_RPOLL2,
    ST_RDAT2,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    IO_IDLE,
    IO_SETUP,
    IO_STROBE,
    IO_RECOV
  } io_phase_e;

  localparam logic [3:0]  OFF_WSTAT = 4'hC;
  localparam logic [3:0]  OFF_RSTAT = 4'hE;
  localparam logic [3:0]  OFF_RDATA = 4'hA;

  localparam logic [15:0] BASE_MIN = 16'h0200;
  localparam logic [15:0] BASE_MAX = 16'h02F0;

  localparam logic [7:0]  DSP_CMD_GET_VERSION = 8'hE1;

  // A DSP base is 16-byte aligned and sits inside the 0x200..0x2F0 window.
  function automatic logic base_is_legal(input logic [15:0] base);
    return (base[3:0] == 4'h0) && (base >= BASE_MIN) && (base <= BASE_MAX);
  endfunction

endpackage

// File: rtl/dsp_version_query_io_cycle.sv
// One ISA I/O access: setup cycle, STROBE_CYCLES of IOR#/IOW# low, recovery cycle.
// A request in the recovery cycle chains straight into the next setup cycle.
module isa_io_cycle
  import dsp_version_query_pkg::*;
#(
  parameter int STROBE_CYCLES = 8
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic [7:0]  data_in,
  output logic [15:0] address,
  output logic [15:0] data_out,
  output logic        data_dir,
  output logic        ior_n,
  output logic        iow_n,
  output logic [7:0]  rdata,
  output logic        ack
);

  localparam int CW = (STROBE_CYCLES > 2) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STROBE_CYCLES - 1);

  io_phase_e     phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [15:0]   address_q, address_d;
  logic [15:0]   data_out_q, data_out_d;
  logic          data_dir_q, data_dir_d;
  logic          ior_n_q, ior_n_d;
  logic          iow_n_q, iow_n_d;
  logic [7:0]    rdata_q, rdata_d;

  always_comb begin
    // NOTE: every _d defaults to its _q so no path through the case leaves a latch.
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    address_d  = address_q;
    data_out_d = data_out_q;
    data_dir_d = data_dir_q;
    ior_n_d    = ior_n_q;
    iow_n_d    = iow_n_q;
    rdata_d    = rdata_q;
    case (phase_q)
      IO_IDLE, IO_RECOV: begin
        if (req) begin
          phase_d    = IO_SETUP;
          address_d  = addr;
          wr_d       = wr;
          data_out_d = wr ? {8'h00, wdata} : 16'h0000;
          data_dir_d = wr;
        end else begin
          phase_d    = IO_IDLE;
          data_dir_d = 1'b0;
        end
      end
      IO_SETUP: begin
        phase_d = IO_STROBE;
        cnt_d   = '0;
        ior_n_d = wr_q;
        iow_n_d = !wr_q;
      end
      IO_STROBE: begin
        if (cnt_q == LAST) begin
          phase_d = IO_RECOV;
          ior_n_d = 1'b1;
          iow_n_d = 1'b1;
          if (!wr_q) rdata_d = data_in;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: phase_d = IO_IDLE;
    endcase
  end

  // NOTE: async reset forces strobes high at once, aborting any access in flight.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      phase_q    <= IO_IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      address_q  <= 16'h0000;
      data_out_q <= 16'h0000;
      data_dir_q <= 1'b0;
      ior_n_q    <= 1'b1;
      iow_n_q    <= 1'b1;
      rdata_q    <= 8'h00;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      address_q  <= address_d;
      data_out_q <= data_out_d;
      data_dir_q <= data_dir_d;
      ior_n_q    <= ior_n_d;
      iow_n_q    <= iow_n_d;
      rdata_q    <= rdata_d;
    end
  end

  assign address  = address_q;
  assign data_out = data_out_q;
  assign data_dir = data_dir_q;
  assign ior_n    = ior_n_q;
  assign iow_n    = iow_n_q;
  assign rdata    = rdata_q;
  assign ack      = (phase_q == IO_RECOV);

endmodule

// File: rtl/dsp_version_query.sv
// SB DSP "get version" exchange: poll, write 0xE1, read major and minor bytes,
// with a saturating poll-attempt timeout and base-port legality check.
module dsp_version_query
  import dsp_version_query_pkg::*;
#(
  parameter int         STROBE_CYCLES = 8,
  parameter int         TIMEOUT_BITS  = 16,
  parameter logic [7:0] DSP_CMD       = DSP_CMD_GET_VERSION
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic [15:0] address,
  output logic        data_dir,
  output logic        iow_n,
  output logic        ior_n,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  version_major,
  output logic [7:0]  version_minor
);

  state_e                  state_q, state_d;
  logic [15:0]             base_q, base_d;
  logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d, tmo_inc;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [7:0]              major_q, major_d;
  logic [7:0]              minor_q, minor_d;

  logic        io_req, io_wr, io_ack, poll_fail;
  logic [3:0]  io_off;
  logic [7:0]  io_wdata, io_rdata;
  logic [15:0] io_base, io_addr;
  logic        unused_data_hi;

  assign unused_data_hi = ^data_in[15:8];
  assign tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + TIMEOUT_BITS'(1);

  // The first access is issued in the same cycle start is accepted, before base_q loads.
  assign io_base = (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR)
                   ? base_addr : base_q;
  assign io_addr = io_base + {12'h000, io_off};

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    tmo_d     = tmo_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    major_d   = major_q;
    minor_d   = minor_q;
    io_req    = 1'b0;
    io_wr     = 1'b0;
    io_off    = OFF_WSTAT;
    io_wdata  = 8'h00;
    poll_fail = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          base_d  = base_addr;
          done_d  = 1'b0;
          major_d = 8'h00;
          minor_d = 8'h00;
          if (base_is_legal(base_addr)) begin
            state_d = ST_WPOLL;
            busy_d  = 1'b1;
            error_d = 1'b0;
            tmo_d   = '0;
            io_req  = 1'b1;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
      ST_WPOLL: begin
        if (io_ack) begin
          if (!io_rdata[7]) begin
            state_d  = ST_WCMD;
            io_req   = 1'b1;
            io_wr    = 1'b1;
            io_wdata = DSP_CMD;
          end else begin
            poll_fail = 1'b1;
          end
        end
      end
      ST_WCMD: begin
        io_off = OFF_RSTAT;
        if (io_ack) begin
          state_d = ST_RPOLL1;
          tmo_d   = '0;
          io_req  = 1'b1;
        end
      end
      ST_RPOLL1, ST_RPOLL2: begin
        io_off = OFF_RSTAT;
        if (io_ack) begin
          if (io_rdata[7]) begin
            state_d = (state_q == ST_RPOLL1) ? ST_RDAT1 : ST_RDAT2;
            io_off  = OFF_RDATA;
            io_req  = 1'b1;
          end else begin
            poll_fail = 1'b1;
          end
        end
      end
      ST_RDAT1: begin
        io_off = OFF_RSTAT;
        if (io_ack) begin
          major_d = io_rdata;
          state_d = ST_RPOLL2;
          tmo_d   = '0;
          io_req  = 1'b1;
        end
      end
      ST_RDAT2: begin
        if (io_ack) begin
          minor_d = io_rdata;
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Failed polls retry the same port until the attempt counter reaches all-ones.
    if (poll_fail) begin
      tmo_d = tmo_inc;
      if (tmo_inc == '1) begin
        state_d = ST_ERR;
        error_d = 1'b1;
        busy_d  = 1'b0;
        major_d = 8'h00;
        minor_d = 8'h00;
      end else begin
        io_req = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      base_q  <= 16'h0000;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      major_q <= 8'h00;
      minor_q <= 8'h00;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      major_q <= major_d;
      minor_q <= minor_d;
    end
  end

  isa_io_cycle #(.STROBE_CYCLES(STROBE_CYCLES)) u_io (
    .sys_clock (sys_clock),
    .reset     (reset),
    .req       (io_req),
    .wr        (io_wr),
    .addr      (io_addr),
    .wdata     (io_wdata),
    .data_in   (data_in[7:0]),
    .address   (address),
    .data_out  (data_out),
    .data_dir  (data_dir),
    .ior_n     (ior_n),
    .iow_n     (iow_n),
    .rdata     (io_rdata),
    .ack       (io_ack)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign version_major = major_q;
  assign version_minor = minor_q;

endmodule

// File: tb/tb_dsp_version_query.sv
// Directed bench for dsp_version_query: a behavioural DSP answers the ISA reads,
// and a second instance with a 4-bit attempt counter exercises the timeout.
module tb_dsp_version_query;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] data_in, data_out, address;
  logic        data_dir, iow_n, ior_n, busy, done, error;
  logic [7:0]  major, minor;

  logic        t_start;
  logic [15:0] t_base;
  logic [15:0] t_data_in, t_data_out, t_address;
  logic        t_data_dir, t_iow_n, t_ior_n, t_busy, t_done, t_error;
  logic [7:0]  t_major, t_minor;

  int n_run  = 0;
  int n_fail = 0;

  // Bus activity seen by the monitors (written only by the monitors).
  int rd_c = 0, rd_e = 0, rd_a = 0, wr_cnt = 0, c_at_wr = 0;
  int ior_low = 0, iow_low = 0, viol = 0, t_rd_e = 0;
  logic [15:0] wr_addr = 16'h0, wr_data = 16'h0;

  // Model controls and per-test marks (written only by the stimulus block).
  int c_mark = 0, e_mark = 0, a_mark = 0, w_mark = 0, rl_mark = 0, wl_mark = 0;
  int c_busy = 0;
  logic e_ready = 1'b1;

  always #5 clk = ~clk;

  dsp_version_query dut (
    .sys_clock(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .data_in(data_in), .data_out(data_out), .address(address), .data_dir(data_dir),
    .iow_n(iow_n), .ior_n(ior_n), .busy(busy), .done(done), .error(error),
    .version_major(major), .version_minor(minor)
  );

  dsp_version_query #(.TIMEOUT_BITS(4)) dut_to (
    .sys_clock(clk), .reset(reset), .start(t_start), .base_addr(t_base),
    .data_in(t_data_in), .data_out(t_data_out), .address(t_address), .data_dir(t_data_dir),
    .iow_n(t_iow_n), .ior_n(t_ior_n), .busy(t_busy), .done(t_done), .error(t_error),
    .version_major(t_major), .version_minor(t_minor)
  );

  // DSP model: write status busy for c_busy polls, read status per e_ready,
  // data port returns 0x04 then 0x05; upper byte carries junk the DUT must ignore.
  always_comb begin
    data_in = 16'hAB00;
    case (address[3:0])
      4'hC: if (rd_c - c_mark < c_busy) data_in = 16'hAB80;
      4'hE: if (e_ready) data_in = 16'hAB80;
      4'hA: data_in = (rd_a == a_mark) ? 16'hAB04 : 16'hAB05;
      default: data_in = 16'hAB00;
    endcase
  end
  assign t_data_in = 16'h0000;

  always @(posedge ior_n) begin
    case (address[3:0])
      4'hC: rd_c++;
      4'hE: rd_e++;
      4'hA: rd_a++;
      default: ;
    endcase
  end

  always @(negedge iow_n) begin
    wr_cnt++;
    wr_addr = address;
    wr_data = data_out;
    c_at_wr = rd_c;
  end

  always @(posedge t_ior_n) if (t_address == 16'h022E) t_rd_e++;

  always @(negedge clk) begin
    if (!ior_n) ior_low++;
    if (!iow_n) iow_low++;
    if (!ior_n && !iow_n) viol++;
    if (!iow_n && data_dir !== 1'b1) viol++;
    if (!ior_n && data_dir !== 1'b0) viol++;
    if (!t_ior_n && !t_iow_n) viol++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] b);
    base_addr = b;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic mark_model();
    c_mark = rd_c; e_mark = rd_e; a_mark = rd_a; w_mark = wr_cnt;
    rl_mark = ior_low; wl_mark = iow_low;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus"}, {address, data_out, data_dir, iow_n, ior_n},
          {16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1});
    check({tag, "_status"}, {busy, done, error, major, minor}, 19'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = 16'h0000;
    t_start = 1'b0; t_base = 16'h0220;
    #12;
    check_reset_outputs("reset");
    check("reset_to", {t_iow_n, t_ior_n, t_busy, t_done, t_error}, 5'b11000);
    tick(1);
    reset = 1'b0;
    tick(2);

    // DSP always ready: 6 accesses, done 61 cycles after start.
    mark_model(); c_busy = 0; e_ready = 1'b1;
    pulse_start(16'h0220);
    check("t1_busy", {busy, done}, 2'b10);
    tick(59);
    check("t1_done_early", done, 1'b0);
    tick(1);
    check("t1_done", {busy, done, error}, 3'b010);
    check("t1_version", {major, minor}, 16'h0405);
    check("t1_write", {wr_addr, wr_data}, {16'h022C, 16'h00E1});
    check("t1_counts", {8'(rd_c - c_mark), 8'(rd_e - e_mark), 8'(rd_a - a_mark), 8'(wr_cnt - w_mark)},
          32'h01020201);
    check("t1_strobe_cycles", {16'(ior_low - rl_mark), 16'(iow_low - wl_mark)}, {16'd40, 16'd8});
    check("t1_idle_bus", {address, data_dir, ior_n, iow_n}, {16'h022A, 3'b011});

    // Write status busy for 3 polls: done 30 cycles later.
    mark_model(); c_busy = 3;
    pulse_start(16'h0220);
    check("t2_done_cleared", {busy, done, major, minor}, 18'h20000);
    tick(89);
    check("t2_done_early", done, 1'b0);
    tick(1);
    check("t2_done", {busy, done, error}, 3'b010);
    check("t2_c_reads_before_wr", c_at_wr - c_mark, 4);
    check("t2_writes", wr_cnt - w_mark, 1);
    check("t2_version", {major, minor}, 16'h0405);
    c_busy = 0;

    // Timeout instance: read status never ready, 15 polls then ERR at cycle 171.
    t_start = 1'b1;
    tick(1);
    t_start = 1'b0;
    check("t3_busy", t_busy, 1'b1);
    tick(169);
    check("t3_error_early", t_error, 1'b0);
    tick(1);
    check("t3_error", {t_busy, t_done, t_error, t_major, t_minor}, 19'h10000);
    check("t3_polls", t_rd_e, 15);

    // Illegal bases: immediate ERR, no bus activity.
    mark_model();
    pulse_start(16'h0225);
    check("t4_misaligned", {busy, done, error}, 3'b001);
    tick(3);
    pulse_start(16'h0300);
    check("t4_above", {busy, done, error}, 3'b001);
    pulse_start(16'h01F0);
    check("t4_below", {busy, done, error}, 3'b001);
    tick(3);
    check("t4_no_bus", {16'(ior_low - rl_mark), 16'(iow_low - wl_mark)}, 32'h0);

    // Async reset in the RDAT1 strobe-low phase, then a clean run at 0x240.
    mark_model();
    pulse_start(16'h0220);
    check("t5_error_cleared", {busy, error}, 2'b10);
    tick(35);
    check("t5_in_rdat1", {address, ior_n}, {16'h022A, 1'b0});
    #2 reset = 1'b1;
    #1 check_reset_outputs("t5_async_reset");
    tick(2);
    reset = 1'b0;
    tick(1);
    mark_model();
    pulse_start(16'h0240);
    tick(59);
    check("t5_done_early", done, 1'b0);
    tick(1);
    check("t5_done", {busy, done, error, major, minor}, 19'h20405);
    check("t5_write", {wr_addr, wr_data}, {16'h024C, 16'h00E1});

    // Start pulsed mid-query is ignored; upper window edge 0x2F0 is legal.
    mark_model();
    pulse_start(16'h02F0);
    tick(18);
    base_addr = 16'h0220;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(40);
    check("t6_done_early", done, 1'b0);
    tick(1);
    check("t6_done", {busy, done, error, major, minor}, 19'h20405);
    check("t6_write", wr_addr, 16'h02FC);
    check("t6_counts", {8'(rd_c - c_mark), 8'(rd_e - e_mark), 8'(rd_a - a_mark), 8'(wr_cnt - w_mark)},
          32'h01020201);
    check("t6_address", address, 16'h02FA);

    check("bus_protocol_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
